vram_arbiter: RTL and testbench

Time-slot arbiter that shares the single-port video RAM between the VGA pixel generator and the CPU data port. The pixel generator never stalls: during active video it owns two fixed slots of every 4-cycle pixel period, and CPU reads and writes are granted only in the remaining slots. During blanking the CPU may use every cycle. It sits between the pixel generator, the CPU bus interface and the synchronous RAM, whose read data is valid the cycle after its address.

---
 rtl/vram_arbiter_if.sv | 48 ++++
 rtl/vram_arbiter.sv | 97 +++++++++
 tb/tb_vram_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | vram_arbiter_if : video, CPU and RAM signal bundle of the VRAM arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface vram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              vid_req;
    logic              vid_active;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_busy;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  vid_req, vid_active, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output vid_rdata, cpu_ack, cpu_rdata, cpu_busy,
        output ram_addr, ram_wdata, ram_we
    );

    // Pixel generator / CPU / RAM side
    modport master (
        output vid_req, vid_active, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_rdata,
        input  vid_rdata, cpu_ack, cpu_rdata, cpu_busy,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface

`default_nettype wire

// File: rtl/vram_arbiter.sv
// +----------------------------------------------------------------------------+
// | vram_arbiter : time-slot arbiter sharing one video RAM port between the    |
// | pixel generator (slots 0/2 in active video) and the CPU.      Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module vram_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        slot_q;
    logic [1:0]        slot_d;
    logic              we_q;
    logic              ack_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              cpu_slot;
    logic              grant;

    assign slot_d   = bus.vid_req ? 2'd0 : slot_q + 2'd1;
    // Odd slots belong to the CPU in active video; blanking frees every cycle
    assign cpu_slot = ~bus.vid_active | slot_q[0];
    assign grant    = (state_q == ST_PEND) & cpu_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= 2'd0;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        we_q    <= bus.cpu_we;
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                        state_q <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (cpu_slot) begin
                        if (we_q) begin
                            ack_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    // RAM output now carries the data addressed in the grant cycle
                    rdata_q <= bus.ram_rdata;
                    ack_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_addr  = grant ? addr_q : bus.vid_addr;
    assign bus.ram_we    = grant & we_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.vid_rdata = bus.ram_rdata;
    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_busy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_vram_arbiter : directed/table-driven bench for vram_arbiter             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_vram_arbiter;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running cycle count; vid_req in cycles == 3 mod 4 makes slot == cyc mod 4
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.vid_req  = (cyc[1:0] == 2'd3);
    assign bus.vid_addr = 24'h800000 | {8'h00, cyc[15:0]};

    logic [15:0] mem [256];
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 16'h1234 : {8'hE0, 8'(i)};
            init_done <= 1'b1;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr[7:0]];
    end

    typedef struct {
        bit          act;
        bit          we;
        logic [23:0] addr;
        logic [15:0] wdata;
        int          slot;   // slot number of cycle E+1
        int          grant;  // grant cycle offset from capture edge
        int          ack;    // ack cycle offset from capture edge
        logic [15:0] rdata;
    } vec_t;

    vec_t        vt [8];
    logic [15:0] shadow [256];
    int          errors = 0;
    int          checks = 0;
    int          ack_cnt = 0;
    logic        prev_ack = 1'b0;
    logic        prev_vvalid = 1'b0;
    logic [23:0] prev_vaddr = '0;
    bit          vid_chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Sample at the falling edge and run the always-on video/ack checks
    task automatic sample();
        @(negedge clk);
        chk("vid_rdata_copy", 32'(bus.vid_rdata), 32'(bus.ram_rdata));
        if (vid_chk_en && bus.vid_active) begin
            if (!cyc[0]) begin
                chk("vid_slot_addr", 32'(bus.ram_addr), 32'(bus.vid_addr));
                chk("vid_slot_we", 32'(bus.ram_we), 32'd0);
                prev_vaddr  = bus.vid_addr;
                prev_vvalid = 1'b1;
            end else if (prev_vvalid) begin
                chk("vid_rdata_slot", 32'(bus.vid_rdata), 32'(mem[prev_vaddr[7:0]]));
                prev_vvalid = 1'b0;
            end
        end else begin
            prev_vvalid = 1'b0;
        end
        if (bus.cpu_ack) begin
            ack_cnt++;
            chk("ack_single", 32'(prev_ack), 32'd0);
        end
        prev_ack = bus.cpu_ack;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic align(input logic [1:0] want);
        for (int n = 0; n < 8 && cyc[1:0] != want; n++) step();
    endtask

    task automatic run_vec(input vec_t v);
        bus.vid_active = v.act;
        align(2'(v.slot + 3));
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = v.we;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        sample();
        chk("vec_idle_busy", 32'(bus.cpu_busy), 32'd0);
        adv();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = ~v.we;
        bus.cpu_addr  = ~v.addr;
        bus.cpu_wdata = ~v.wdata;
        for (int k = 1; k <= v.ack + 1; k++) begin
            sample();
            if (k == v.grant) begin
                chk("vec_grant_addr", 32'(bus.ram_addr), 32'(v.addr));
                chk("vec_grant_we", 32'(bus.ram_we), 32'(v.we));
                if (v.we) chk("vec_grant_wdata", 32'(bus.ram_wdata), 32'(v.wdata));
            end else begin
                chk("vec_video_addr", 32'(bus.ram_addr), 32'(bus.vid_addr));
                chk("vec_video_we", 32'(bus.ram_we), 32'd0);
            end
            chk("vec_busy", 32'(bus.cpu_busy), 32'(k < v.ack));
            chk("vec_ack", 32'(bus.cpu_ack), 32'(k == v.ack));
            if (k == v.ack && !v.we) chk("vec_rdata", 32'(bus.cpu_rdata), 32'(v.rdata));
            adv();
        end
        if (v.we) shadow[v.addr[7:0]] = v.wdata;
    endtask

    initial begin
        int unsigned start;
        int          req_cnt;
        int          ack_base;
        int          exp_ack;
        bit          rwe;
        logic [23:0] raddr;
        logic [15:0] rwd;

        for (int i = 0; i < 256; i++) shadow[i] = (i == 16) ? 16'h1234 : {8'hE0, 8'(i)};
        bus.vid_active = 1'b0;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;

        //           act   we    addr        wdata     slot grant ack rdata
        vt[0] = '{1'b0, 1'b1, 24'h000123, 16'hBEEF, 0, 1, 2, 16'h0000};
        vt[1] = '{1'b0, 1'b0, 24'h000010, 16'h0000, 0, 1, 3, 16'h1234};
        vt[2] = '{1'b1, 1'b0, 24'h000010, 16'h0000, 2, 2, 4, 16'h1234};
        vt[3] = '{1'b1, 1'b1, 24'h000040, 16'h5A5A, 1, 1, 2, 16'h0000};
        vt[4] = '{1'b1, 1'b1, 24'h000041, 16'hC3C3, 0, 2, 3, 16'h0000};
        vt[5] = '{1'b1, 1'b0, 24'h000040, 16'h0000, 3, 1, 3, 16'h5A5A};
        vt[6] = '{1'b1, 1'b0, 24'h000123, 16'h0000, 0, 2, 4, 16'hBEEF};
        vt[7] = '{1'b0, 1'b0, 24'h000041, 16'h0000, 2, 1, 3, 16'hC3C3};

        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample();
        chk("rst_ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_busy", 32'(bus.cpu_busy), 32'd0);
        chk("rst_we", 32'(bus.ram_we), 32'd0);
        chk("rst_addr", 32'(bus.ram_addr), 32'(bus.vid_addr));
        adv();
        repeat (6) step();
        vid_chk_en = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Back-to-back writes in blanking: captures at E, E+2, E+4
        bus.vid_active = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 8; k++) begin
            bus.cpu_req   = (k <= 4);
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = 24'h000060 + 24'(k / 2);
            bus.cpu_wdata = 16'h7000 + 16'(k / 2);
            sample();
            chk("b2b_ack", 32'(bus.cpu_ack), 32'(k == 2 || k == 4 || k == 6));
            chk("b2b_we", 32'(bus.ram_we), 32'(k == 1 || k == 3 || k == 5));
            if (k == 1 || k == 3 || k == 5) begin
                chk("b2b_addr", 32'(bus.ram_addr), 32'(24'h000060 + 24'((k - 1) / 2)));
                chk("b2b_wdata", 32'(bus.ram_wdata), 32'(16'h7000 + 16'((k - 1) / 2)));
            end
            adv();
        end
        for (int j = 0; j < 3; j++) shadow[8'h60 + 8'(j)] = 16'h7000 + 16'(j);

        // Reset while a write waits in a video slot
        bus.vid_active = 1'b1;
        align(2'd3);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 24'h000050;
        bus.cpu_wdata = 16'hDEAD;
        step();
        bus.cpu_req = 1'b0;
        sample();
        chk("rstmid_busy", 32'(bus.cpu_busy), 32'd1);
        chk("rstmid_we", 32'(bus.ram_we), 32'd0);
        #1;
        rst_n      = 1'b0;
        vid_chk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            adv();
            sample();
            chk("rstmid_ack", 32'(bus.cpu_ack), 32'd0);
            chk("rstmid_we_low", 32'(bus.ram_we), 32'd0);
            chk("rstmid_busy_low", 32'(bus.cpu_busy), 32'd0);
        end
        adv();
        rst_n = 1'b1;
        sample();
        chk("rstrel_busy", 32'(bus.cpu_busy), 32'd0);
        chk("rstrel_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rstrel_ack", 32'(bus.cpu_ack), 32'd0);
        adv();
        repeat (6) step();
        chk("rstmid_no_write", 32'(mem[8'h50]), 32'(shadow[8'h50]));
        vid_chk_en = 1'b1;

        // Random CPU traffic over 1000 pixel periods of active video
        bus.vid_active = 1'b1;
        start    = cyc;
        req_cnt  = 0;
        ack_base = ack_cnt;
        while (cyc - start < 4000) begin
            repeat ($urandom_range(0, 3)) step();
            rwe   = 1'($urandom_range(0, 1));
            raddr = 24'h000080 + 24'($urandom_range(0, 15));
            rwd   = 16'($urandom);
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = rwe;
            bus.cpu_addr  = raddr;
            bus.cpu_wdata = rwd;
            step();
            req_cnt++;
            bus.cpu_req   = 1'b0;
            bus.cpu_addr  = ~raddr;
            bus.cpu_wdata = ~rwd;
            exp_ack = 3;
            for (int k = 1; k <= exp_ack + 1; k++) begin
                sample();
                if (k == 1) exp_ack = (rwe ? 2 : 3) + (cyc[0] ? 0 : 1);
                chk("rnd_ack", 32'(bus.cpu_ack), 32'(k == exp_ack));
                if (k == exp_ack && !rwe) chk("rnd_rdata", 32'(bus.cpu_rdata), 32'(shadow[raddr[7:0]]));
                adv();
            end
            if (rwe) shadow[raddr[7:0]] = rwd;
        end
        chk("rnd_ack_count", 32'(ack_cnt - ack_base), 32'(req_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
